// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one memory between the IF fetch port and the
// MEM data port through an IDLE/ISSUE/WAIT sequencer, with starvation guard and fetch flush.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [11:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [11:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_ready,
    input  logic        flush,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t     state, state_nxt;
    owner_t     owner;
    logic [3:0] streak;
    logic       if_kill;
    logic       grant_if, grant_dm;

    // IF only beats a pending DM request once DM has used up its streak allowance.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            grant_if = if_req && !flush && (!dm_req || streak == LIMIT);
            grant_dm = dm_req && !grant_if;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_if || grant_dm) state_nxt = ISSUE;
            ISSUE:   state_nxt = mem_we ? IDLE : WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_IF;
            streak    <= 4'd0;
            if_kill   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 12'd0;
            mem_wdata <= 16'd0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= 16'd0;
            dm_rdata  <= 16'd0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        owner     <= grant_dm ? OWN_DM : OWN_IF;
                        if_kill   <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_dm && dm_we;
                        mem_addr  <= grant_dm ? dm_addr : if_addr;
                        mem_wdata <= grant_dm ? dm_wdata : mem_wdata;
                    end
                    if (grant_if)
                        streak <= 4'd0;
                    else if (grant_dm) begin
                        if (!if_req)             streak <= 4'd0;
                        else if (streak != LIMIT) streak <= streak + 4'd1;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    if (mem_we) dm_ready <= 1'b1;
                    if (owner == OWN_IF && flush) if_kill <= 1'b1;
                end
                WAIT: begin
                    // A fetch flushed at any point in flight still finishes its memory
                    // access but must not deliver the stale instruction.
                    if (owner == OWN_DM) begin
                        dm_rdata <= mem_rdata;
                        dm_ready <= 1'b1;
                    end else if (!(if_kill || flush)) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall = (if_req && !if_ready) || (dm_req && !dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (STARVE_LIMIT 4 and 1) share
// stimulus, each backed by a behavioural single-port memory with one-cycle read latency.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, flush;
    logic [11:0] if_addr, dm_addr;
    logic [15:0] dm_wdata;

    logic [15:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, stall, mem_en, mem_we;
    logic [11:0] mem_addr;

    logic [15:0] if_rdata2, dm_rdata2, mem_wdata2, mem_rdata2;
    logic        if_ready2, dm_ready2, stall2, mem_en2, mem_we2;
    logic [11:0] mem_addr2;

    logic [15:0] m1 [0:4095];
    logic [15:0] m2 [0:4095];

    typedef struct {
        logic        port;   // 0 = IF, 1 = DM
        logic [15:0] data;
    } exp_t;
    exp_t        exp_q[$];
    logic [11:0] g1_q[$];
    logic [11:0] g2_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .flush(flush), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.STARVE_LIMIT(1)) dut2 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata2), .if_ready(if_ready2),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata2), .dm_ready(dm_ready2), .flush(flush), .stall(stall2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) m1[mem_addr] <= mem_wdata;
            else        mem_rdata    <= m1[mem_addr];
        end
        if (mem_en2) begin
            if (mem_we2) m2[mem_addr2] <= mem_wdata2;
            else         mem_rdata2    <= m2[mem_addr2];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_en !== 1'b0)     begin n_err++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 12'd0)  begin n_err++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'd0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0000", mem_wdata); end
        n_cmp++; if ({if_ready, dm_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {if_ready, dm_ready}); end
        n_cmp++; if ({if_rdata, dm_rdata} !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", {if_rdata, dm_rdata}); end
        n_cmp++; if (stall !== 1'b0)      begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_if_read;
        exp_t e;
        if_req = 1'b1; if_addr = 12'h010;
        exp_q.push_back('{1'b0, 16'hA5A5});
        #1;
        n_cmp++; if (stall !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL ifrd_c0 got stall=%b en=%b want 1 0", stall, mem_en); end
        tick();
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010 || stall !== 1'b1) begin
            n_err++; $display("FAIL ifrd_c1 got en=%b we=%b addr=%h stall=%b want 1 0 010 1", mem_en, mem_we, mem_addr, stall); end
        tick();
        n_cmp++; if (mem_en !== 1'b0 || if_ready !== 1'b0 || stall !== 1'b1 || mem_rdata !== 16'hA5A5) begin
            n_err++; $display("FAIL ifrd_c2 got en=%b rdy=%b stall=%b mrd=%h want 0 0 1 a5a5", mem_en, if_ready, stall, mem_rdata); end
        tick();
        n_cmp++; if (if_ready !== 1'b1 || stall !== 1'b0 || dm_ready !== 1'b0) begin
            n_err++; $display("FAIL ifrd_c3 got rdy=%b stall=%b dmrdy=%b want 1 0 0", if_ready, stall, dm_ready); end
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL ifrd_sb queue empty want 1 entry"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (e.port !== 1'b0 || if_rdata !== e.data) begin n_err++; $display("FAIL ifrd_data got %h want %h", if_rdata, e.data); end
        end
        if_req = 1'b0;
        tick();
        n_cmp++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL ifrd_c4 got rdy=%b en=%b want 0 0", if_ready, mem_en); end
    endtask

    task automatic test_write;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h400; dm_wdata = 16'h1234;
        tick();
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h400 || mem_wdata !== 16'h1234) begin
            n_err++; $display("FAIL wr_c1 got en=%b we=%b addr=%h wd=%h want 1 1 400 1234", mem_en, mem_we, mem_addr, mem_wdata); end
        tick();
        n_cmp++; if (dm_ready !== 1'b1 || if_ready !== 1'b0 || mem_en !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL wr_c2 got dmrdy=%b ifrdy=%b en=%b stall=%b want 1 0 0 0", dm_ready, if_ready, mem_en, stall); end
        dm_req = 1'b0;
        tick();
        n_cmp++; if (m1[12'h400] !== 16'h1234 || dm_ready !== 1'b0) begin
            n_err++; $display("FAIL wr_mem got %h rdy=%b want 1234 0", m1[12'h400], dm_ready); end
    endtask

    task automatic test_back_to_back;
        int hits400 = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h400; dm_wdata = 16'h1111;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (mem_en && mem_addr == 12'h400) hits400++;
            if (c == 2) begin
                n_cmp++; if (dm_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1 got %b want 1", dm_ready); end
                dm_addr = 12'h402; dm_wdata = 16'h2222;
            end
            if (c == 3) begin
                n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 12'h402 || mem_wdata !== 16'h2222) begin
                    n_err++; $display("FAIL b2b_c3 got en=%b addr=%h wd=%h want 1 402 2222", mem_en, mem_addr, mem_wdata); end
            end
            if (c == 4) begin
                n_cmp++; if (dm_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy2 got %b want 1", dm_ready); end
                dm_req = 1'b0;
            end
        end
        n_cmp++; if (hits400 != 1) begin n_err++; $display("FAIL b2b_dup got %0d accesses to 400 want 1", hits400); end
        tick();
        n_cmp++; if (m1[12'h402] !== 16'h2222 || m1[12'h400] !== 16'h1111) begin
            n_err++; $display("FAIL b2b_mem got %h %h want 1111 2222", m1[12'h400], m1[12'h402]); end
    endtask

    task automatic test_starvation;
        int budget = 0;
        logic [11:0] a;
        for (int i = 0; i < 10; i++) begin
            g1_q.push_back((i % 5 == 4) ? 12'h100 : 12'h200);
            g2_q.push_back((i % 2 == 1) ? 12'h100 : 12'h200);
        end
        if_req = 1'b1; if_addr = 12'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200;
        while ((g1_q.size() != 0 || g2_q.size() != 0) && budget < 60) begin
            tick();
            budget++;
            if (if_ready && dm_ready) begin n_cmp++; n_err++; $display("FAIL starve_two_ready both high at cycle %0d", budget); end
            if (mem_en && g1_q.size() != 0) begin
                a = g1_q.pop_front();
                n_cmp++; if (mem_addr !== a) begin n_err++; $display("FAIL starve_lim4 got %h want %h", mem_addr, a); end
            end
            if (mem_en2 && g2_q.size() != 0) begin
                a = g2_q.pop_front();
                n_cmp++; if (mem_addr2 !== a) begin n_err++; $display("FAIL starve_lim1 got %h want %h", mem_addr2, a); end
            end
        end
        if (budget >= 60) begin n_cmp++; n_err++; $display("FAIL starve_timeout got %0d/%0d left want 0/0", g1_q.size(), g2_q.size()); end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) tick();
        n_cmp++; if (if_rdata !== 16'h1001 || dm_rdata !== 16'h2002) begin
            n_err++; $display("FAIL starve_data got %h %h want 1001 2002", if_rdata, dm_rdata); end
    endtask

    task automatic test_flush;
        exp_t e;
        if_req = 1'b1; if_addr = 12'h030;
        tick();
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 12'h030) begin n_err++; $display("FAIL fl_c1 got en=%b addr=%h want 1 030", mem_en, mem_addr); end
        tick();
        flush = 1'b1; if_addr = 12'h020;
        exp_q.push_back('{1'b0, 16'hC0DE});
        tick();
        flush = 1'b0;
        n_cmp++; if (if_ready !== 1'b0 || if_rdata !== 16'h1001) begin
            n_err++; $display("FAIL fl_suppress got rdy=%b data=%h want 0 1001", if_ready, if_rdata); end
        tick();
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 12'h020) begin n_err++; $display("FAIL fl_regrant got en=%b addr=%h want 1 020", mem_en, mem_addr); end
        tick();
        tick();
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL fl_rdy got %b want 1", if_ready); end
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL fl_sb queue empty want 1 entry"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (if_rdata !== e.data) begin n_err++; $display("FAIL fl_data got %h want %h", if_rdata, e.data); end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        exp_t e;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200;
        tick();
        tick();
        reset = 1'b1; dm_req = 1'b0;
        #1;
        n_cmp++; if (mem_en !== 1'b0 || mem_addr !== 12'h000 || dm_ready !== 1'b0 || if_rdata !== 16'd0 || dm_rdata !== 16'd0) begin
            n_err++; $display("FAIL rstmid_async got en=%b addr=%h rdy=%b ird=%h drd=%h want 0 000 0 0 0", mem_en, mem_addr, dm_ready, if_rdata, dm_rdata); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (dm_ready !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL rstmid_nordy got rdy=%b en=%b want 0 0", dm_ready, mem_en); end
        dm_req = 1'b1;
        exp_q.push_back('{1'b1, 16'h2002});
        tick();
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 12'h200) begin n_err++; $display("FAIL rstmid_c1 got en=%b addr=%h want 1 200", mem_en, mem_addr); end
        tick();
        n_cmp++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_c2 got rdy=%b want 0", dm_ready); end
        tick();
        n_cmp++; if (dm_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_c3 got rdy=%b want 1", dm_ready); end
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL rstmid_sb queue empty want 1 entry"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if (e.port !== 1'b1 || dm_rdata !== e.data) begin n_err++; $display("FAIL rstmid_data got %h want %h", dm_rdata, e.data); end
        end
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; flush = 1'b0;
        if_addr = 12'd0; dm_addr = 12'd0; dm_wdata = 16'd0;
        for (int i = 0; i < 4096; i++) begin
            m1[i] = 16'd0;
            m2[i] = 16'd0;
        end
        m1[12'h010] = 16'hA5A5; m2[12'h010] = 16'hA5A5;
        m1[12'h020] = 16'hC0DE; m2[12'h020] = 16'hC0DE;
        m1[12'h030] = 16'hBEEF; m2[12'h030] = 16'hBEEF;
        m1[12'h100] = 16'h1001; m2[12'h100] = 16'h1001;
        m1[12'h200] = 16'h2002; m2[12'h200] = 16'h2002;
        test_reset();
        test_if_read();
        test_write();
        test_back_to_back();
        test_starvation();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the 16-bit five-stage pipeline. It shares one unified memory array between the IF-stage instruction fetch port and the MEM-stage data port, sequencing each access through a fixed issue/wait state machine. It drives a pipeline-wide stall while either requester is unserved, and cancels fetches on a taken jump or branch (PCSrc).

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants made while if_req is pending before one instruction grant is forced; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction read request; held until if_ready.
- if_addr  in  12  instruction byte address (IF Instruction_addressbus).
- if_rdata  out  16  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the instruction port.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read (MEM Memory_writemode).
- dm_addr  in  12  data byte address.
- dm_wdata  in  16  write data.
- dm_rdata  out  16  read data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for the data port.
- flush  in  1  PCSrc from MEM; cancels any instruction transaction.
- stall  out  1  freeze IF/ID/EX/MEM pipeline registers.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  12  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid exactly one cycle after a read strobe.

## Operation
- States: IDLE, ISSUE, WAIT. Owner register records which port (IF or DM) holds the current grant.
- IDLE: evaluate requests.
  - If no request is eligible, stay in IDLE.
  - Eligible requests are dm_req, and if_req when flush=0.
  - Default priority is DM over IF.
  - IF wins when if_req is eligible and streak==STARVE_LIMIT.
  - On a grant, latch owner, address, wdata and we (we=0 for IF), then go to ISSUE.
- ISSUE: mem_en=1; mem_we/mem_addr/mem_wdata come from the latched values.
  - Write: go to IDLE and set dm_ready=1 for the next cycle.
  - Read: go to WAIT.
- WAIT:
  - Capture mem_rdata into if_rdata or dm_rdata (by owner).
  - Pulse the owner's ready in the next cycle.
  - Go to IDLE.
- Flush:
  - When flush=1 in ISSUE or WAIT with owner=IF, the memory access still completes as sequenced.
  - if_ready is suppressed and if_rdata is left unchanged.
  - The block returns to IDLE on the normal schedule.
  - DM transactions ignore flush.
- A request that is high in the same cycle as its port's ready pulse is a new transaction; the pipeline advances on that edge, so the request now carries the next address.
- streak counter (4 bit, saturating at STARVE_LIMIT):
  - +1 on a DM grant while if_req=1.
  - Cleared on an IF grant.
  - Cleared on a DM grant while if_req=0.
- stall = (if_req & ~if_ready) | (dm_req & ~dm_ready). This is combinational, built from the inputs and the registered ready signals.
- Addresses and data pass unmodified; no alignment checks.

## Timing
- Reset (asynchronous): state=IDLE, owner=IF, streak=0, and mem_en=mem_we=0, mem_addr=0, mem_wdata=0, if_ready=dm_ready=0, if_rdata=dm_rdata=0 immediately. stall then follows its inputs.
- Reset in mid-transaction abandons the access; no ready pulse.
- mem_en, mem_we, mem_addr, mem_wdata, ready and rdata outputs are all registered.
- Read latency: request sampled in IDLE at cycle 0; mem_en in cycle 1; data in cycle 2; ready and rdata in cycle 3.
- Write latency: request at cycle 0; mem_en/mem_we in cycle 1; dm_ready in cycle 2.
- Back-to-back throughput: a new grant can occur in the ready cycle. The result is 3 cycles per read and 2 cycles per write.
- mem_en is high for exactly one cycle per grant and never in IDLE or WAIT.
- Ready pulses are exactly one cycle wide, and at most one ready is high per cycle.
- Simultaneous flush and if_req in IDLE: if_req is ignored that cycle; dm_req may still be granted.

## Test plan
- IF read alone: if_req=1, if_addr=0x010 at cycle 0; mem_rdata=0xA5A5 at cycle 2 → mem_en=1, mem_addr=0x010 only in cycle 1; if_ready=1, if_rdata=0xA5A5 in cycle 3; stall high in cycles 0–2, low in cycle 3.
- Data write: dm_req=1, dm_we=1, dm_addr=0x400, dm_wdata=0x1234 → cycle 1 shows mem_en=mem_we=1, addr 0x400, wdata 0x1234; dm_ready in cycle 2; if_ready stays 0.
- Contention and starvation: STARVE_LIMIT=4; if_req and dm_req (read) are held continuously → exactly 4 DM grants, then 1 IF grant, then the pattern repeats. Check streak saturation with STARVE_LIMIT=1, which must give alternating grants.
- Flush: IF read granted; flush=1 during WAIT → no if_ready, if_rdata unchanged, back in IDLE next cycle; next if_req at 0x020 is served normally with ready 3 cycles later.
- Reset mid-read: reset asserted in WAIT (owner=DM) → all outputs are 0 asynchronously; after release, no dm_ready appears, and a re-presented dm_req completes with full 3-cycle latency.
- Ready-cycle re-request: dm write completes with dm_ready while dm_req stays high with a new address, 0x402 → the next mem_en shows 0x402 one cycle after dm_ready, with no duplicate access to 0x400.
